rns_dot_accumulator: RTL
========================

# rns_dot_accumulator

Streaming residue-number-system multiply-accumulate stage that sits directly downstream of `convertor_int_to_rns` and upstream of `convertor_rns_to_int`. It accepts pairs of packed 4-lane RNS words and accumulates their lane-wise modular products over a vector delimited by `in_last`. It emits one packed RNS dot-product word per vector, ready for conversion back to integer. All arithmetic is carry-free per lane; no cross-lane interaction.

## Interface
- `M0`, default 251: modulus of lane 0, bits [7:0]
- `M1`, default 241: modulus of lane 1, bits [15:8]
- `M2`, default 239: modulus of lane 2, bits [23:16]
- `M3`, default 233: modulus of lane 3, bits [31:24] (product of defaults = 3368562317)
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: input beat valid
- `in_ready` output 1: block can accept a beat
- `in_a` input 32: packed RNS operand A
- `in_b` input 32: packed RNS operand B
- `in_last` input 1: beat is final element of the vector
- `out_valid` output 1: result valid
- `out_ready` input 1: consumer accepts result
- `out_rns` output 32: packed RNS dot product
- `out_len` output 16: number of beats in the vector, saturating at 0xFFFF

## Operation
- FSM states: ACC, DRAIN, OUT. Reset → ACC.
- ACC: `in_ready`=1. Beat accepted when `in_valid && in_ready`. Each lane computes p = (a_i * b_i) mod M_i (16-bit product, full reduction), registered in stage 1. Stage 2: acc_i = acc_i + p; if acc_i ≥ M_i, subtract M_i. Beat counter increments, saturates at 0xFFFF.
- Accepted beat with `in_last`=1 → DRAIN. `in_ready`=0 from the next cycle.
- DRAIN: wait for the last product to reach the accumulator, then → OUT.
- OUT: `out_valid`=1; `out_rns`/`out_len` are stable while `out_ready`=0. On `out_valid && out_ready`: clear accumulators and counter, → ACC.
- Non-canonical input residues (≥ M_i) must still give correct mod results because stage 1 fully reduces. The accumulator is always canonical.
- `in_valid` with `in_ready`=0 is ignored. Inputs are don't-care when not accepted.
- Reset values: `in_ready`=0 during the reset cycle and 1 on the first cycle after. `out_valid`=0, `out_rns`=0, `out_len`=0, accumulators 0, pipeline valid bits 0.
- Reset mid-vector or during OUT discards all partial/pending results.

## Timing
- Throughput: one beat per cycle in ACC, back-to-back.
- Latency: last beat accepted at edge E. Its product is registered at E and accumulated at E+1. `out_valid` is high in the cycle after edge E+2.
- After the result handshake at edge H, `in_ready` is 1 in the cycle after H. There is no combinational path from `out_ready` to `in_ready`.
- `out_rns`/`out_len` are registered outputs. `out_rns` includes every accepted beat of the vector, including the last.

## Structure
- Package `rns_pkg` holds:
  - lane width constant 8 and lane count 4;
  - default moduli;
  - typedef `rns_word_t` (packed 4×8);
  - function `mod_add(a, b, m)` (conditional subtract).
- Sub-module `rns_lane_mac` (parameter M): stage-1 multiply/reduce register and stage-2 accumulator for one lane, with clear and enable inputs. Instantiate it 4×.
- The top level holds the FSM, beat counter, pipeline valid and handshake logic.

## Test plan
- Single beat: `in_a`=0x442C24F7 (1000), `in_b`=0x01010101, `in_last`=1 → `out_rns`=0x442C24F7, `out_len`=1, `out_valid` in the cycle after E+2.
- Wrap: two beats of `in_a`=0xE8EEF0FA (−1), `in_b`=0x01010101 → `out_rns`=0xE7EDEFF9 (−2), `out_len`=2. Also a single beat of 0xE8EEF0FA × 0xE8EEF0FA → 0x01010101.
- Non-canonical: `in_a`=0xFFFFFFFF, `in_b`=0x01010101, last → `out_rns`=0x16100E04.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `out_valid`, `out_rns` and `out_len` are stable and `in_ready`=0. Then `out_ready`=1 → handshake, and `in_ready`=1 on the next cycle. The next vector starts from a zero accumulator.
- Reset mid-vector: 3 beats accepted, then `rst` for 1 cycle, then a single beat 0x01010101×0x01010101 last → `out_rns`=0x01010101, `out_len`=1.
- Streaming: 100 random canonical beats with random `in_valid` gaps → `out_rns` matches a per-lane modular reference model, and its CRT conversion matches the integer dot product mod 3368562317.

Source files
------------

// File: rtl/rns_dot_accumulator_pkg.sv
// Shared definitions for the RNS dot-product accumulator.
//   - lane geometry (4 lanes of 8 bits) and default moduli
//   - rns_word_t: packed 4-lane residue word, lane i in bits [8*i+7:8*i]
//   - state_t:    accumulator FSM states, also exported for debug
//   - mod_add:    canonical modular add for one lane
package rns_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 4;

  localparam int unsigned M0_DEF = 251;
  localparam int unsigned M1_DEF = 241;
  localparam int unsigned M2_DEF = 239;
  localparam int unsigned M3_DEF = 233;

  typedef logic [LANES-1:0][LANE_W-1:0] rns_word_t;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Both operands are canonical (< m), so the sum is < 2m and one
  // conditional subtract brings it back into range.
  function automatic logic [LANE_W-1:0] mod_add(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b,
                                                input logic [LANE_W:0]   m);
    logic [LANE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= m) s = s - m;
    return s[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/rns_dot_accumulator_if.sv
// Handshake bundle for rns_dot_accumulator.
//   in_valid/in_ready/in_a/in_b/in_last : input beat stream
//   out_valid/out_ready/out_rns/out_len : one result per vector
// Valid/ready: a transfer happens on a rising edge where valid and ready
// are both high. A producer holding valid keeps its data stable until the
// transfer; valid never waits on ready. ready may be asserted at any time.
interface rns_dot_accumulator_if;

  logic              in_valid;
  logic              in_ready;
  rns_pkg::rns_word_t in_a;
  rns_pkg::rns_word_t in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  rns_pkg::rns_word_t out_rns;
  logic [15:0]       out_len;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_rns, out_len
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_rns, out_len
  );

endinterface

// File: rtl/rns_dot_accumulator_lane_mac.sv
// One RNS lane: stage 1 registers (a*b) mod M, stage 2 folds it into a
// canonical running sum.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : zero the accumulator (wins over acc_en_i)
//   load_i     : capture the reduced product of a_i*b_i
//   acc_en_i   : add the registered product into the accumulator
//   a_i, b_i   : lane residues, may be non-canonical (up to 255)
//   acc_o      : canonical accumulator value
module rns_lane_mac
  import rns_pkg::*;
#(
  parameter int unsigned M = 251
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              acc_en_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] acc_o
);

  localparam logic [15:0]     M16 = 16'(M);
  localparam logic [LANE_W:0] M9  = (LANE_W+1)'(M);

  logic [15:0]       prod;
  logic [LANE_W-1:0] red;
  logic [LANE_W-1:0] p_q;
  logic [LANE_W-1:0] acc_q;

  // Full reduction of the 16-bit product makes non-canonical inputs safe.
  always_comb begin
    prod = 16'(a_i) * 16'(b_i);
    red  = LANE_W'(prod % M16);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) p_q <= red;
      if (clr_i)         acc_q <= '0;
      else if (acc_en_i) acc_q <= mod_add(acc_q, p_q, M9);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/rns_dot_accumulator.sv
// Streaming RNS multiply-accumulate: accumulates lane-wise modular products
// of (in_a, in_b) over a vector ended by in_last, then presents one packed
// dot-product word with the beat count.
//   clk, rst     : clock, synchronous active-high reset
//   bus_if       : slave side of rns_dot_accumulator_if (beats in, result out)
//   dbg_state_o  : current FSM state
module rns_dot_accumulator
  import rns_pkg::*;
#(
  parameter int unsigned M0 = M0_DEF,
  parameter int unsigned M1 = M1_DEF,
  parameter int unsigned M2 = M2_DEF,
  parameter int unsigned M3 = M3_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  rns_dot_accumulator_if.slave  bus_if,
  output state_t                dbg_state_o
);

  localparam int unsigned MODS [LANES] = '{M0, M1, M2, M3};

  state_t      state_q, state_d;
  logic        in_ready_q;
  logic        v1_q;
  logic [15:0] cnt_q;
  rns_word_t   out_rns_q;
  logic [15:0] out_len_q;
  rns_word_t   acc_w;

  logic accept;
  logic done;
  logic load_out;

  assign accept = bus_if.in_valid && in_ready_q && (state_q == ST_ACC);
  assign done   = (state_q == ST_OUT) && bus_if.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Next state. DRAIN waits until the last product has left stage 1,
  // i.e. the accumulator already holds every beat of the vector.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:   if (accept && bus_if.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!v1_q)                    state_d = ST_OUT;
      ST_OUT:   if (bus_if.out_ready)         state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  // Outputs
  always_comb begin
    bus_if.out_valid = (state_q == ST_OUT);
    load_out         = (state_q == ST_DRAIN) && !v1_q;
    dbg_state_o      = state_q;
  end

  // in_ready is registered from the next state so out_ready never reaches
  // it combinationally, and it is low throughout the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      v1_q       <= 1'b0;
      cnt_q      <= '0;
      out_rns_q  <= '0;
      out_len_q  <= '0;
    end else begin
      in_ready_q <= (state_d == ST_ACC);
      v1_q       <= accept;
      if (done)                           cnt_q <= '0;
      else if (accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      if (load_out) begin
        out_rns_q <= acc_w;
        out_len_q <= cnt_q;
      end
    end
  end

  assign bus_if.in_ready = in_ready_q;
  assign bus_if.out_rns  = out_rns_q;
  assign bus_if.out_len  = out_len_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rns_lane_mac #(.M(MODS[g])) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (done),
      .load_i   (accept),
      .acc_en_i (v1_q),
      .a_i      (bus_if.in_a[g]),
      .b_i      (bus_if.in_b[g]),
      .acc_o    (acc_w[g])
    );
  end

endmodule
